// File: rtl/conv_filt_5x5.sv
// conv_filt_5x5: programmable signed 5x5 convolution on 24-bit RGB pixels.
// Five vertically aligned taps (pa..pe) are shifted into a 5-column window.
// Each channel is convolved with the kernel, then rounded, shifted and saturated.
// The status is delayed to match the fixed 6-cycle latency.
// Build option: define CONV_FILT_COEF_SHADOW_EN to stage kernel writes in a shadow bank.
// The active bank then copies the shadow on the input-side VSYNC rising edge.
module conv_filt_5x5 #(
    parameter int unsigned COEF_W = 8,
    parameter int unsigned SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       pa,
    input  logic [23:0]       pb,
    input  logic [23:0]       pc,
    input  logic [23:0]       pd,
    input  logic [23:0]       pe,
    input  logic [2:0]        stat_in,
    input  logic              coef_we,
    input  logic [4:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_din,
    output logic [23:0]       data_out,
    output logic [2:0]        stat_o
);

    localparam int unsigned NTAP   = 25;
    localparam int unsigned PROD_W = COEF_W + 9;
    localparam int unsigned SUM_W  = COEF_W + 14;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam coef_t K_ID = coef_t'(2 ** SHIFT);
    localparam sum_t  RND  = sum_t'((2 ** SHIFT) / 2);

    logic  coef_wr;
    coef_t kern_q [NTAP];
    coef_t kern_d [NTAP];

    assign coef_wr = coef_we && (coef_addr < 5'd25);

`ifdef CONV_FILT_COEF_SHADOW_EN
    coef_t shad_q [NTAP];
    coef_t shad_d [NTAP];
    logic  vs_q, vs_d;

    // Writes land in the shadow; the whole shadow goes live on VSYNC rising.
    always_comb begin
        shad_d = shad_q;
        kern_d = kern_q;
        vs_d   = stat_in[2];
        if (coef_wr) shad_d[coef_addr] = coef_din;
        if (stat_in[2] && !vs_q) kern_d = shad_q;
    end

    // Shadow bank and VSYNC edge detector; both banks reset to identity.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                kern_q[i] <= (i == 12) ? K_ID : '0;
                shad_q[i] <= (i == 12) ? K_ID : '0;
            end
            vs_q <= 1'b0;
        end else begin
            kern_q <= kern_d;
            shad_q <= shad_d;
            vs_q   <= vs_d;
        end
    end
`else
    // Writes update the active kernel directly.
    always_comb begin
        kern_d = kern_q;
        if (coef_wr) kern_d[coef_addr] = coef_din;
    end

    // Active kernel register, identity after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) kern_q[i] <= (i == 12) ? K_ID : '0;
        end else begin
            kern_q <= kern_d;
        end
    end
`endif

    // Column c of the window, row r at bits [r*24 +: 24]; column 0 is the newest.
    logic [119:0] win_q  [5];
    logic [119:0] win_d  [5];
    logic [2:0]   stat_q [6];
    logic [2:0]   stat_d [6];
    prod_t        prod_q [3][NTAP];
    prod_t        prod_d [3][NTAP];
    sum_t         rsum_q [3][5];
    sum_t         rsum_d [3][5];
    logic [23:0]  out_q, out_d;
    sum_t         tot    [3];
    sum_t         shv    [3];

    // Column capture with zero padding outside DE, window shift and status delay.
    always_comb begin
        win_d[0] = stat_in[0] ? {pe, pd, pc, pb, pa} : '0;
        for (int i = 1; i < 5; i++) win_d[i] = win_q[i-1];
        stat_d[0] = stat_in;
        for (int i = 1; i < 6; i++) stat_d[i] = stat_q[i-1];
    end

    // 75 products: unsigned pixel times signed coefficient.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    prod_d[ch][r*5+c] = prod_t'($signed({1'b0, win_q[c][r*24 + ch*8 +: 8]}))
                                      * prod_t'(kern_q[r*5+c]);
                end
            end
        end
    end

    // Per-channel row sums.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 5; r++) begin
                rsum_d[ch][r] = '0;
                for (int c = 0; c < 5; c++) begin
                    rsum_d[ch][r] = rsum_d[ch][r] + sum_t'(prod_q[ch][r*5+c]);
                end
            end
        end
    end

    // Final sum, round-half-up, arithmetic shift and clamp to 0..255.
    always_comb begin
        out_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            tot[ch] = '0;
            for (int r = 0; r < 5; r++) tot[ch] = tot[ch] + rsum_q[ch][r];
            shv[ch] = (tot[ch] + RND) >>> SHIFT;
            if (shv[ch] < 0) begin
                out_d[ch*8 +: 8] = 8'h00;
            end else if (shv[ch] > sum_t'(255)) begin
                out_d[ch*8 +: 8] = 8'hFF;
            end else begin
                out_d[ch*8 +: 8] = shv[ch][7:0];
            end
        end
    end

    // Pipeline registers; reset flushes everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) win_q[i] <= '0;
            for (int i = 0; i < 6; i++) stat_q[i] <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                for (int i = 0; i < NTAP; i++) prod_q[ch][i] <= '0;
                for (int r = 0; r < 5; r++) rsum_q[ch][r] <= '0;
            end
            out_q <= '0;
        end else begin
            win_q  <= win_d;
            stat_q <= stat_d;
            prod_q <= prod_d;
            rsum_q <= rsum_d;
            out_q  <= out_d;
        end
    end

    assign data_out = out_q;
    assign stat_o   = stat_q[5];

endmodule

// File: tb/tb_conv_filt_5x5.sv
// tb_conv_filt_5x5: directed bench for conv_filt_5x5 with hand-computed expectations.
// An expectation queue models the 6-cycle latency; entries whose window or kernel
// straddles a change are marked as not checked. Status is checked every cycle.
module tb_conv_filt_5x5;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pa, pb, pc, pd, pe;
    logic [2:0]  stat_in;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [7:0]  coef_din;
    logic [23:0] data_out;
    logic [2:0]  stat_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] q_dat [$];
    logic [2:0]  q_st  [$];
    bit          q_vld [$];

    conv_filt_5x5 #(.COEF_W(8), .SHIFT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pa        (pa),
        .pb        (pb),
        .pc        (pc),
        .pd        (pd),
        .pe        (pe),
        .stat_in   (stat_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_din  (coef_din),
        .data_out  (data_out),
        .stat_o    (stat_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %06h want %06h", tag, got, want);
        end
    endtask

    // Reset for one clock, then the pipeline holds zeros for the next five outputs.
    task automatic do_reset(input string tag);
        rst = 1'b1; pa = 24'h111111; pb = 24'h222222; pc = 24'h333333;
        pd = 24'h444444; pe = 24'h555555; stat_in = 3'b111; coef_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq({tag, " rst data"}, data_out, 24'h0);
        check_eq({tag, " rst stat"}, {21'd0, stat_o}, 24'h0);
        q_dat.delete(); q_st.delete(); q_vld.delete();
        for (int i = 0; i < 5; i++) begin
            q_dat.push_back(24'h0); q_st.push_back(3'b000); q_vld.push_back(1'b1);
        end
    endtask

    // One clock: drive taps, queue the expectation, compare the output that is due.
    task automatic cyc(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic [23:0] d, input logic [23:0] e,
                       input logic [2:0] s, input logic [23:0] want, input bit vld);
        logic [23:0] wd;
        logic [2:0]  ws;
        bit          wv;
        pa = a; pb = b; pc = c; pd = d; pe = e; stat_in = s;
        q_dat.push_back(want); q_st.push_back(s); q_vld.push_back(vld);
        @(posedge clk); #1;
        coef_we = 1'b0;
        wd = q_dat.pop_front(); ws = q_st.pop_front(); wv = q_vld.pop_front();
        if (wv) check_eq({tag, " data"}, data_out, wd);
        check_eq({tag, " stat"}, {21'd0, stat_o}, {21'd0, ws});
    endtask

    task automatic col(input string tag, input logic [23:0] pix, input logic [2:0] s,
                       input logic [23:0] want, input bit vld);
        cyc(tag, 24'h0, 24'h0, pix, 24'h0, 24'h0, s, want, vld);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) col("idle", 24'h0, 3'b000, 24'h0, 1'b0);
    endtask

    task automatic wr(input int addr, input logic [7:0] val);
        coef_we = 1'b1; coef_addr = 5'(addr); coef_din = val;
        col("wr", 24'h0, 3'b000, 24'h0, 1'b0);
    endtask

    // Make written coefficients live (VSYNC pulse in the shadowed build).
    task automatic commit();
`ifdef CONV_FILT_COEF_SHADOW_EN
        col("commit", 24'h0, 3'b100, 24'h0, 1'b0);
        col("commit", 24'h0, 3'b000, 24'h0, 1'b0);
`endif
    endtask

    initial begin
        logic [23:0] v;
        logic [2:0]  s;
        rst = 1'b1; pa = '0; pb = '0; pc = '0; pd = '0; pe = '0;
        stat_in = '0; coef_we = 1'b0; coef_addr = '0; coef_din = '0;
        @(posedge clk); #1;
        do_reset("init");

        // Identity pass-through; neighbours nonzero, DE toggles, sync bits vary.
        for (int k = 0; k < 20; k++) begin
            s = 3'(k);
            v = {8'(k * 7 + 1), 8'(k * 3), 8'(200 - k)};
            cyc("t1 ident", 24'h123456, 24'hABCDEF, v, 24'h00FF00, 24'hFEDCBA, s,
                s[0] ? v : 24'h0, 1'b1);
        end

        // All-ones kernel on a flat 0x10 field: 25*16>>4 = 25.
        idle(3);
        for (int i = 0; i < 25; i++) wr(i, 8'd1);
        commit();
        idle(4);
        for (int k = 0; k < 12; k++) begin
            cyc("t2 box", 24'h101010, 24'h101010, 24'h101010, 24'h101010, 24'h101010,
                3'b001, 24'h191919, (k >= 2) && (k <= 9));
        end

        // Box kernel, 0xFF field, DE low two cycles at line start (zero padding).
        idle(6);
        for (int k = 0; k < 2; k++) begin
            cyc("t4 pad", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                3'b010, (k == 0) ? 24'h505050 : 24'h9F9F9F, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            cyc("t4 line", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                3'b001, (k == 0) ? 24'hEFEFEF : 24'hFFFFFF, k <= 5);
        end

        // Centre-only kernels after reset: negative clamp, positive clamp, rounding.
        do_reset("t3");
        wr(12, 8'hF0);
        wr(29, 8'h7F);
        commit();
        col("t3 neg", 24'h808080, 3'b001, 24'h000000, 1'b1);
        col("t3 neg", 24'h010101, 3'b001, 24'h000000, 1'b1);
        col("t3 neg", 24'hFFFFFF, 3'b001, 24'h000000, 1'b1);
        idle(3);
        wr(12, 8'h7F);
        commit();
        col("t3 pos", 24'hFFFFFF, 3'b001, 24'hFFFFFF, 1'b1);
        col("t3 pos", 24'h010101, 3'b001, 24'h080808, 1'b1);
        col("t3 pos", 24'h000000, 3'b001, 24'h000000, 1'b1);
        idle(3);
        wr(12, 8'd24);
        commit();
        col("t3 rnd", 24'h030201, 3'b001, 24'h050302, 1'b1);
        col("t3 rnd", 24'h101010, 3'b001, 24'h181818, 1'b1);
        col("t3 rnd", 24'h0B0B0B, 3'b011, 24'h111111, 1'b1);

        // Reset mid-line: flush, kernel back to identity, pass-through resumes.
        do_reset("t6");
        for (int k = 0; k < 8; k++) begin
            v = {8'(k + 9), 8'(k * 17), 8'(k * 29 + 3)};
            col("t6 ident", v, 3'b001, v, 1'b1);
        end

        // Kernel write of k[12]=0 while streaming.
        for (int k = 0; k < 4; k++) col("t5 pre", 24'h445566, 3'b001, 24'h445566, 1'b1);
`ifdef CONV_FILT_COEF_SHADOW_EN
        wr(12, 8'd0);
        for (int k = 0; k < 6; k++) col("t5 hold", 24'h445566, 3'b001, 24'h445566, 1'b1);
        for (int k = 0; k < 2; k++) col("t5 edge", 24'h445566, 3'b001, 24'h0, 1'b0);
        for (int k = 0; k < 3; k++) col("t5 edge", 24'h445566, 3'b101, 24'h0, 1'b0);
        for (int k = 0; k < 6; k++) col("t5 zero", 24'h445566, 3'b101, 24'h000000, 1'b1);
`else
        for (int k = 0; k < 2; k++) col("t5 edge", 24'h445566, 3'b001, 24'h0, 1'b0);
        wr(12, 8'd0);
        for (int k = 0; k < 6; k++) col("t5 zero", 24'h445566, 3'b001, 24'h000000, 1'b1);
`endif
        idle(6);

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
